l1_refill_ctrl: RTL

- Refill and write-through sequencer between the unified L1 (I/D) cache and the 8-bit system memory bus.
- Takes the L1's one-hot-in-time requests (write_through_req, read_req, read_line_req) plus pa/wt_data.
- Drives a simple req/ack byte bus.
- Returns line_data, addr_count, line_write, cache_entry_refill, trans_rdy and bus_error with the timing the L1 state machine expects.

---
 rtl/l1_refill_pkg.sv | 38 +++
 rtl/l1_bus_watchdog.sv | 31 +++
 rtl/l1_refill_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/l1_refill_pkg.sv
// Shared types and constants for the L1 refill / write-through sequencer.
// State encoding, default line geometry and request-priority selection.
package l1_refill_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WT   = 3'd1;
    localparam state_t ST_RS   = 3'd2;
    localparam state_t ST_RL   = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    localparam int unsigned L1_LINE_SIZE = 128;
    localparam int unsigned L1_LINE_WID  = $clog2(L1_LINE_SIZE);

    typedef logic [1:0] req_t;

    localparam req_t REQ_NONE = 2'd0;
    localparam req_t REQ_WT   = 2'd1;
    localparam req_t REQ_RL   = 2'd2;
    localparam req_t REQ_RS   = 2'd3;

    // Write-through beats line refill, line refill beats single read.
    function automatic req_t req_select(input logic wt, input logic rl, input logic rs);
        if (wt) begin
            return REQ_WT;
        end
        if (rl) begin
            return REQ_RL;
        end
        if (rs) begin
            return REQ_RS;
        end
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/l1_bus_watchdog.sv
// Per-beat bus wait counter; flags a beat that has waited TIMEOUT cycles.
// Only instantiated when L1_REFILL_TIMEOUT_EN is defined.
module l1_bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of cycles the current beat has already waited
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // This cycle is the TIMEOUT-th unanswered one; an ack now still wins.
    assign expire_c = en && !clr && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/l1_refill_ctrl.sv
// Refill / write-through sequencer between the unified L1 and the 8-bit req/ack bus.
// Optional per-beat timeout enabled by defining L1_REFILL_TIMEOUT_EN.
module l1_refill_ctrl
    import l1_refill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned LINE_SIZE  = L1_LINE_SIZE,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              write_through_req,
    input  logic                              read_req,
    input  logic                              read_line_req,
    input  logic [ADDR_WIDTH-1:0]             pa,
    input  logic [7:0]                        wt_data,
    output logic [7:0]                        line_data,
    output logic [$clog2(LINE_SIZE)-1:0]      addr_count,
    output logic                              line_write,
    output logic                              cache_entry_refill,
    output logic                              trans_rdy,
    output logic                              bus_error,
    output logic                              bus_req,
    output logic                              bus_we,
    output logic [ADDR_WIDTH-1:0]             bus_addr,
    output logic [7:0]                        bus_wdata,
    input  logic [7:0]                        bus_rdata,
    input  logic                              bus_ack,
    input  logic                              bus_err
);

    localparam int unsigned LINE_WID = $clog2(LINE_SIZE);
    localparam int unsigned BASE_W   = ADDR_WIDTH - LINE_WID;

    state_t                 state, state_nxt;
    logic [LINE_WID-1:0]    cnt, cnt_nxt;
    logic [BASE_W-1:0]      base, base_nxt;
    logic [7:0]             line_data_nxt;
    logic [LINE_WID-1:0]    addr_count_nxt;
    logic                   line_write_nxt;
    logic                   refill_nxt;
    logic                   trans_rdy_nxt;
    logic                   bus_error_nxt;
    logic                   bus_req_nxt;
    logic                   bus_we_nxt;
    logic [ADDR_WIDTH-1:0]  bus_addr_nxt;
    logic [7:0]             bus_wdata_nxt;
    req_t                   req_sel_c;
    logic                   req_active_c;
    logic                   fault_c;
    logic                   last_beat_c;
    logic                   wd_expire_c;

`ifdef L1_REFILL_TIMEOUT_EN
    l1_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus_ack | ~bus_req),
        .en       (bus_req),
        .expire_c (wd_expire_c)
    );
`else
    assign wd_expire_c = 1'b0;
`endif

    // Registered state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            base               <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            base               <= base_nxt;
            line_data          <= line_data_nxt;
            addr_count         <= addr_count_nxt;
            line_write         <= line_write_nxt;
            cache_entry_refill <= refill_nxt;
            trans_rdy          <= trans_rdy_nxt;
            bus_error          <= bus_error_nxt;
            bus_req            <= bus_req_nxt;
            bus_we             <= bus_we_nxt;
            bus_addr           <= bus_addr_nxt;
            bus_wdata          <= bus_wdata_nxt;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        base_nxt       = base;
        line_data_nxt  = line_data;
        addr_count_nxt = addr_count;
        line_write_nxt = 1'b0;
        refill_nxt     = 1'b0;
        trans_rdy_nxt  = 1'b0;
        bus_error_nxt  = 1'b0;
        bus_req_nxt    = bus_req;
        bus_we_nxt     = bus_we;
        bus_addr_nxt   = bus_addr;
        bus_wdata_nxt  = bus_wdata;

        req_sel_c    = req_select(write_through_req, read_line_req, read_req);
        fault_c      = bus_err || wd_expire_c;
        last_beat_c  = (cnt == LINE_WID'(LINE_SIZE - 1));
        req_active_c = 1'b0;
        case (state)
            ST_WT:   req_active_c = write_through_req;
            ST_RS:   req_active_c = read_req;
            ST_RL:   req_active_c = read_line_req;
            default: req_active_c = 1'b0;
        endcase

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (req_sel_c != REQ_NONE) begin
                    base_nxt      = pa[ADDR_WIDTH-1:LINE_WID];
                    bus_wdata_nxt = wt_data;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = (req_sel_c == REQ_WT);
                    bus_addr_nxt  = pa;
                end
                case (req_sel_c)
                    REQ_WT:  state_nxt = ST_WT;
                    REQ_RS:  state_nxt = ST_RS;
                    REQ_RL: begin
                        state_nxt    = ST_RL;
                        bus_addr_nxt = {pa[ADDR_WIDTH-1:LINE_WID], LINE_WID'(0)};
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end

            ST_WT, ST_RS: begin
                if (fault_c) begin
                    state_nxt     = ST_ERR;
                    bus_req_nxt   = 1'b0;
                    bus_we_nxt    = 1'b0;
                    bus_error_nxt = 1'b1;
                end else if (bus_ack) begin
                    bus_req_nxt = 1'b0;
                    bus_we_nxt  = 1'b0;
                    if (state == ST_RS) begin
                        line_data_nxt = bus_rdata;
                    end
                    // A withdrawn request completes its beat silently
                    if (req_active_c) begin
                        state_nxt     = ST_DONE;
                        trans_rdy_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RL: begin
                if (fault_c) begin
                    state_nxt     = ST_ERR;
                    bus_req_nxt   = 1'b0;
                    bus_error_nxt = 1'b1;
                end else if (bus_ack) begin
                    line_data_nxt  = bus_rdata;
                    addr_count_nxt = cnt;
                    line_write_nxt = 1'b1;
                    cnt_nxt        = cnt + LINE_WID'(1);
                    bus_addr_nxt   = {base, cnt + LINE_WID'(1)};
                    if (last_beat_c || !req_active_c) begin
                        bus_req_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end
                    // Final byte write lands in DONE together with the tag commit
                    if (last_beat_c && req_active_c) begin
                        state_nxt     = ST_DONE;
                        trans_rdy_nxt = 1'b1;
                        refill_nxt    = 1'b1;
                    end
                end
            end

            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
